// File: rtl/dieu_khien_che_do_if.sv
// Button inputs and counter-facing outputs of the mode controller.
// The master drives the raw buttons; the slave (the controller) drives everything else.
interface dieu_khien_che_do_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] mode;
  logic       btn_up_o;
  logic       btn_down_o;
  logic       editing;
  logic       blink;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  mode, btn_up_o, btn_down_o, editing, blink
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output mode, btn_up_o, btn_down_o, editing, blink
  );
endinterface

// File: rtl/dieu_khien_che_do.sv
// Clock/date setting mode controller: mode presses walk the edit fields, up/down are qualified
// per field. Define DKCD_AUTO_EXIT_EN to add the idle counter that returns to RUN after TIMEOUT clocks.
module dieu_khien_che_do #(
  parameter int unsigned TIMEOUT = 30
) (
  input logic                clk_1Hz,
  input logic                rst_n,
  dieu_khien_che_do_if.slave ctrl
);

  typedef enum logic [2:0] {
    RUN   = 3'b000,
    SEC   = 3'b001,
    MIN   = 3'b010,
    HOUR  = 3'b011,
    DAY   = 3'b100,
    MONTH = 3'b101,
    YEAR  = 3'b110,
    BAD   = 3'b111
  } state_e;

  state_e     state_q, state_d;
  logic       btn_mode_q, btn_mode_prev_q, btn_up_q, btn_down_q;
  logic [2:0] mode_q, mode_d;
  logic       up_o_q, up_o_d;
  logic       down_o_q, down_o_d;
  logic       editing_q, editing_d;
  logic       blink_q, blink_d;
  logic       mode_evt, any_press, both_press, in_edit;

  if (TIMEOUT < 2 || TIMEOUT > 63) begin : g_timeout_range
    $error("dieu_khien_che_do: TIMEOUT must lie within 2..63");
  end

`ifdef DKCD_AUTO_EXIT_EN
  localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT - 1);
  logic [5:0] idle_q, idle_d;
`endif

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      btn_mode_q      <= 1'b1;
      btn_mode_prev_q <= 1'b1;
      btn_up_q        <= 1'b1;
      btn_down_q      <= 1'b1;
    end else begin
      btn_mode_q      <= ctrl.btn_mode;
      btn_mode_prev_q <= btn_mode_q;
      btn_up_q        <= ctrl.btn_up;
      btn_down_q      <= ctrl.btn_down;
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mode_q    <= '1;
      up_o_q    <= 1'b1;
      down_o_q  <= 1'b1;
      editing_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      up_o_q    <= up_o_d;
      down_o_q  <= down_o_d;
      editing_q <= editing_d;
      blink_q   <= blink_d;
    end
  end

`ifdef DKCD_AUTO_EXIT_EN
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  always_comb begin
    mode_evt   = btn_mode_prev_q & ~btn_mode_q;
    any_press  = ~(btn_mode_q & btn_up_q & btn_down_q);
    both_press = ~btn_up_q & ~btn_down_q;
    in_edit    = (state_q != RUN) && (state_q != BAD);

    state_d = state_q;
    if (state_q == BAD) begin
      state_d = RUN;
    end else if (mode_evt) begin
      state_d = (state_q == YEAR) ? RUN : state_e'(state_q + 3'd1);
`ifdef DKCD_AUTO_EXIT_EN
    end else if (in_edit && !any_press && idle_q == IDLE_LAST) begin
      state_d = RUN;
`endif
    end

    // Outputs are registered from the next state so they always line up with state_q.
    mode_d    = ~state_d;
    editing_d = (state_d != RUN);

    up_o_d   = 1'b1;
    down_o_d = 1'b1;
    if (in_edit && !mode_evt && !both_press) begin
      up_o_d   = btn_up_q;
      down_o_d = btn_down_q;
    end

    blink_d = 1'b0;
    if (state_d != RUN) begin
      blink_d = (state_d != state_q) ? 1'b1 : ~blink_q;
    end

`ifdef DKCD_AUTO_EXIT_EN
    if (state_d == RUN || state_d != state_q || any_press) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 6'd1;
    end
`endif
  end

  assign ctrl.mode       = mode_q;
  assign ctrl.btn_up_o   = up_o_q;
  assign ctrl.btn_down_o = down_o_q;
  assign ctrl.editing    = editing_q;
  assign ctrl.blink      = blink_q;

endmodule

// File: tb/tb_dieu_khien_che_do.sv
// Self-checking bench for dieu_khien_che_do: a field-index model checked every cycle plus
// directed scenarios with literal expectations.
module tb_dieu_khien_che_do;

  localparam int TO = 30;
`ifdef DKCD_AUTO_EXIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk_1Hz = 1'b0;
  logic rst_n   = 1'b1;
  logic chk_en  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  dieu_khien_che_do_if ctrl();

  dieu_khien_che_do #(.TIMEOUT(TO)) dut (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .ctrl    (ctrl)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: field index 0..6 (0 = RUN), samples seen one clock late, cycles since entry / last press.
  int m_state, m_age, m_idle, nxt;
  bit s_mode, s_prev, s_up, s_down, e_up, e_down, evt, press, both;

  always @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_age = 0; m_idle = 0;
      s_mode = 1; s_prev = 1; s_up = 1; s_down = 1;
      e_up = 1; e_down = 1;
    end else begin
      evt   = s_prev && !s_mode;
      press = !(s_mode && s_up && s_down);
      both  = !s_up && !s_down;
      nxt   = m_state;
      if (evt) nxt = (m_state + 1) % 7;
      else if (AUTO && m_state != 0 && !press && m_idle == TO - 1) nxt = 0;
      e_up   = (m_state != 0 && !evt && !both) ? s_up   : 1'b1;
      e_down = (m_state != 0 && !evt && !both) ? s_down : 1'b1;
      if (nxt != m_state) begin
        m_age = 0; m_idle = 0;
      end else begin
        m_age  = m_age + 1;
        m_idle = press ? 0 : m_idle + 1;
      end
      if (nxt == 0) m_idle = 0;
      m_state = nxt;
      s_prev = s_mode;
      s_mode = ctrl.btn_mode;
      s_up   = ctrl.btn_up;
      s_down = ctrl.btn_down;
    end
  end

  always @(negedge clk_1Hz) begin
    if (chk_en) begin
      chk("model_mode",    {29'd0, ctrl.mode}, 32'(7 - m_state));
      chk("model_editing", {31'd0, ctrl.editing}, {31'd0, m_state != 0});
      chk("model_blink",   {31'd0, ctrl.blink}, {31'd0, (m_state != 0) && (m_age % 2 == 0)});
      chk("model_up_o",    {31'd0, ctrl.btn_up_o}, {31'd0, e_up});
      chk("model_down_o",  {31'd0, ctrl.btn_down_o}, {31'd0, e_down});
    end
  end

  task automatic step();
    @(negedge clk_1Hz);
  endtask

  // One-clock mode press followed by two released clocks; mode/editing checked once the advance lands.
  task automatic press_mode(input logic [2:0] exp_mode, input logic exp_edit);
    ctrl.btn_mode = 1'b0;
    step();
    ctrl.btn_mode = 1'b1;
    step();
    chk("press_mode", {29'd0, ctrl.mode}, {29'd0, exp_mode});
    chk("press_editing", {31'd0, ctrl.editing}, {31'd0, exp_edit});
    step();
  endtask

  logic [1:0] run_pat [6];
  logic       up_pat  [6];
  logic [2:0] seq_mode [7];

  initial begin
    ctrl.btn_mode = 1'b1;
    ctrl.btn_up   = 1'b1;
    ctrl.btn_down = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mode",    {29'd0, ctrl.mode}, 32'h7);
    chk("rst_up_o",    {31'd0, ctrl.btn_up_o}, 32'h1);
    chk("rst_down_o",  {31'd0, ctrl.btn_down_o}, 32'h1);
    chk("rst_editing", {31'd0, ctrl.editing}, 32'h0);
    chk("rst_blink",   {31'd0, ctrl.blink}, 32'h0);
    repeat (2) step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // RUN ignores up/down in every combination
    run_pat = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11};
    for (int i = 0; i < 6; i++) begin
      {ctrl.btn_up, ctrl.btn_down} = run_pat[i];
      step();
      chk("run_up_o",   {31'd0, ctrl.btn_up_o}, 32'h1);
      chk("run_down_o", {31'd0, ctrl.btn_down_o}, 32'h1);
    end

    // full field cycle
    seq_mode = '{3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b111};
    for (int i = 0; i < 7; i++) press_mode(seq_mode[i], i < 6);

    // MIN: up held 4 clocks -> 4 commands, one clock behind
    press_mode(3'b110, 1'b1);
    press_mode(3'b101, 1'b1);
    up_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ctrl.btn_up = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("min_up_o",   {31'd0, ctrl.btn_up_o}, {31'd0, up_pat[k]});
      chk("min_down_o", {31'd0, ctrl.btn_down_o}, 32'h1);
      if (k == 3) ctrl.btn_up = 1'b1;
    end

    // HOUR: up and down together cancel
    press_mode(3'b100, 1'b1);
    ctrl.btn_up = 1'b0; ctrl.btn_down = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("both_up_o",   {31'd0, ctrl.btn_up_o}, 32'h1);
      chk("both_down_o", {31'd0, ctrl.btn_down_o}, 32'h1);
      chk("both_mode",   {29'd0, ctrl.mode}, 32'h4);
      if (k == 2) begin ctrl.btn_up = 1'b1; ctrl.btn_down = 1'b1; end
    end

    // mode press with up held: the advance wins that cycle, the command follows afterwards
    ctrl.btn_mode = 1'b0; ctrl.btn_up = 1'b0;
    step();
    ctrl.btn_mode = 1'b1;
    step();
    chk("adv_mode", {29'd0, ctrl.mode}, 32'h3);
    chk("adv_up_o", {31'd0, ctrl.btn_up_o}, 32'h1);
    ctrl.btn_up = 1'b1;
    step();
    chk("adv_up_after", {31'd0, ctrl.btn_up_o}, 32'h0);
    step();

    // YEAR with down held, then reset mid-cycle
    press_mode(3'b010, 1'b1);
    press_mode(3'b001, 1'b1);
    ctrl.btn_down = 1'b0;
    step();
    step();
    chk("year_down_o", {31'd0, ctrl.btn_down_o}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mode",    {29'd0, ctrl.mode}, 32'h7);
    chk("mid_rst_up_o",    {31'd0, ctrl.btn_up_o}, 32'h1);
    chk("mid_rst_down_o",  {31'd0, ctrl.btn_down_o}, 32'h1);
    chk("mid_rst_editing", {31'd0, ctrl.editing}, 32'h0);
    chk("mid_rst_blink",   {31'd0, ctrl.blink}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_down_o", {31'd0, ctrl.btn_down_o}, 32'h1);
    chk("post_rst_mode",   {29'd0, ctrl.mode}, 32'h7);
    ctrl.btn_down = 1'b1;
    step();

    // DAY idle: press at clock 20 restarts the timeout count
    press_mode(3'b110, 1'b1);
    press_mode(3'b101, 1'b1);
    press_mode(3'b100, 1'b1);
    press_mode(3'b011, 1'b1);
    repeat (18) step();
    ctrl.btn_up = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 1)  ctrl.btn_up = 1'b1;
      if (k == 11) chk("idle_restart_editing", {31'd0, ctrl.editing}, 32'h1);
      if (k == 31) chk("idle_last_editing", {31'd0, ctrl.editing}, 32'h1);
    end
    chk("idle_exit_editing", {31'd0, ctrl.editing}, {31'd0, !AUTO});
    chk("idle_exit_mode",    {29'd0, ctrl.mode}, AUTO ? 32'h7 : 32'h3);
    if (!AUTO) begin
      press_mode(3'b010, 1'b1);
      press_mode(3'b001, 1'b1);
      press_mode(3'b111, 1'b0);
    end
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
